// File: rtl/ex_stage.sv
// EX pipeline stage: ALU, branch-target adder and the EX/MEM register.
// Define EX_MULT_EN to include the iterative shift-add multiplier; otherwise MUL decodes as undefined.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_flush,
  input  logic [6:0]  in_ctrl,
  input  logic [3:0]  in_alu_op,
  input  logic        in_alu_src,
  input  logic        in_reg_dst,
  input  logic [31:0] in_read_data_1,
  input  logic [31:0] in_read_data_2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc_plus4,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  output logic [6:0]  ctrl_out,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [4:0]  write_back_destination,
  output logic        stall
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1001;
`ifdef EX_MULT_EN
  localparam logic [3:0] OpMul = 4'b1010;
`endif

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic [31:0] res;
  logic [31:0] br_tgt;
  logic [4:0]  dest;
  logic        bubble;

  always_comb begin
    op_b   = in_alu_src ? in_imm : in_read_data_2;
    shamt  = in_imm[10:6];
    br_tgt = in_pc_plus4 + {in_imm[29:0], 2'b00};
    dest   = in_reg_dst ? in_rd : in_rt;
    alu_res = 32'd0;
    case (in_alu_op)
      OpAnd:   alu_res = in_read_data_1 & op_b;
      OpOr:    alu_res = in_read_data_1 | op_b;
      OpAdd:   alu_res = in_read_data_1 + op_b;
      OpSub:   alu_res = in_read_data_1 - op_b;
      OpSlt:   alu_res = ($signed(in_read_data_1) < $signed(op_b)) ? 32'd1 : 32'd0;
      OpNor:   alu_res = ~(in_read_data_1 | op_b);
      OpSll:   alu_res = op_b << shamt;
      OpSrl:   alu_res = op_b >> shamt;
      default: alu_res = 32'd0;
    endcase
  end

`ifdef EX_MULT_EN
  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic [31:0] mul_acc_q;
  logic [31:0] mul_acc_d;
  logic        is_mul;

  // The last iteration is folded into the value registered on the final edge.
  assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : 32'd0);
  assign is_mul    = (in_alu_op == OpMul);
  assign stall     = !rst && (((state_q == StIdle) && is_mul) ||
                              ((state_q == StBusy) && (cnt_q != 5'd31)));

  always_comb begin
    bubble = in_flush || stall;
    res    = (state_q == StBusy) ? mul_acc_d : alu_res;
  end
`else
  assign stall = 1'b0;

  always_comb begin
    bubble = in_flush;
    res    = alu_res;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_out               <= 7'd0;
      alu_result             <= 32'd0;
      write_data             <= 32'd0;
      branch_target          <= 32'd0;
      zero                   <= 1'b0;
      write_back_destination <= 5'd0;
`ifdef EX_MULT_EN
      state_q                <= StIdle;
      cnt_q                  <= 5'd0;
      mul_a_q                <= 32'd0;
      mul_b_q                <= 32'd0;
      mul_acc_q              <= 32'd0;
`endif
    end else begin
      if (bubble) begin
        ctrl_out               <= 7'd0;
        alu_result             <= 32'd0;
        write_data             <= 32'd0;
        branch_target          <= 32'd0;
        zero                   <= 1'b0;
        write_back_destination <= 5'd0;
      end else begin
        ctrl_out               <= in_ctrl;
        alu_result             <= res;
        write_data             <= in_read_data_2;
        branch_target          <= br_tgt;
        zero                   <= (res == 32'd0);
        write_back_destination <= dest;
      end
`ifdef EX_MULT_EN
      if (in_flush) begin
        state_q <= StIdle;
        cnt_q   <= 5'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (is_mul) begin
              state_q   <= StBusy;
              cnt_q     <= 5'd0;
              mul_a_q   <= in_read_data_1;
              mul_b_q   <= op_b;
              mul_acc_q <= 32'd0;
            end
          end
          StBusy: begin
            mul_acc_q <= mul_acc_d;
            mul_a_q   <= mul_a_q << 1;
            mul_b_q   <= mul_b_q >> 1;
            cnt_q     <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
`endif
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous active-high reset, rst; it SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_flush  input  1  replace current instruction with bubble at next edge.
REQ-005 in_ctrl  input  7  {mem_to_reg, reg_write, mem_read, mem_write, branch, load_mode[1:0]} from ID/EX.
REQ-006 in_alu_op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 SLL, 1001 SRL, 1010 MUL.
REQ-007 in_alu_src  input  1  operand B select: 1 = in_imm, 0 = in_read_data_2.
REQ-008 in_reg_dst  input  1  destination select: 1 = in_rd, 0 = in_rt.
REQ-009 in_read_data_1 / in_read_data_2  input  32 each  register operands A / store data.
REQ-010 in_imm  input  32  sign-extended immediate; bits [10:6] are the shift amount.
REQ-011 in_pc_plus4  input  32  PC+4 of the instruction.
REQ-012 in_rt / in_rd  input  5 each  candidate destination registers.
REQ-013 ctrl_out  output  7  registered copy of in_ctrl, same bit order, for the MEM stage.
REQ-014 alu_result / write_data / branch_target  output  32 each  registered ALU result, registered in_read_data_2, registered branch target.
REQ-015 zero  output  1  registered (ALU result == 0).
REQ-016 write_back_destination  output  5  registered selected destination register.
REQ-017 stall  output  1  combinational; while high, upstream SHALL hold all in_* stable and not advance.

Function
REQ-018 All outputs except stall SHALL form the EX/MEM register, updated only on a clk rising edge; single-cycle operation latency is 1 edge.
REQ-019 Operand B = in_alu_src ? in_imm : in_read_data_2; SLT is signed (result 1 or 0); SLL/SRL shift operand B by in_imm[10:6]; ADD/SUB wrap modulo 2^32; undefined opcodes yield 0.
REQ-020 branch_target = in_pc_plus4 + (in_imm << 2), modulo 2^32, computed for every instruction.
REQ-021 A bubble SHALL drive ctrl_out = 0; the data outputs are don't-care but SHALL be driven to 0.
REQ-022 MUL SHALL use a shift-add iterative FSM with states IDLE and BUSY and a 5-bit counter; result = low 32 bits of A*B, unsigned.
REQ-023 IDLE with MUL present: stall = 1; the edge loads the operands, clears the counter, enters BUSY and registers a bubble.
REQ-024 BUSY: one iteration per edge; stall = 1 for counter 0..30, a bubble is registered on each of those edges and the counter increments.
REQ-025 BUSY at counter 31: stall = 0; that edge registers the final product with in_ctrl and the destination, and returns the FSM to IDLE; the product appears 33 edges after MUL is first presented.
REQ-026 in_flush high at an edge SHALL register a bubble and force IDLE, aborting any MUL; flush takes priority over completion.
REQ-027 The stall output SHALL be 0 in IDLE unless MUL is present, and 0 whenever rst is high.

Reset
REQ-028 rst high SHALL immediately clear all registered outputs, the FSM (to IDLE), the counter and the multiplier datapath to 0, including mid-MUL.
REQ-029 The first edge after rst falls SHALL process in_* normally.

Configuration
REQ-030 Macro EX_MULT_EN defined: the MUL FSM SHALL be present as specified above.
REQ-031 Macro EX_MULT_EN undefined: no FSM or counter; MUL SHALL be treated as an undefined opcode (result 0, 1-edge latency); stall SHALL be tied to 0.

Verification
REQ-032 ADD, A=5, B=7 (in_alu_src=0) -> after 1 edge alu_result=12, zero=0, ctrl_out=in_ctrl.
REQ-033 SUB, A=9, B=9, branch set, in_pc_plus4=0x100, in_imm=0xFFFFFFFF -> zero=1, branch_target=0xFC.
REQ-034 MUL, A=6, B=7 -> stall high for 32 cycles with bubbles out, then alu_result=42 at edge 33; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-035 in_flush pulsed at counter 10 of a MUL -> bubble, stall=0, next instruction executes normally.
REQ-036 rst asserted mid-MUL -> all outputs 0 without a clock edge; SLT with A=-1, B=1 after release -> alu_result=1.
